ipsl_pcie_dma_tx_arb: RTL and testbench
=======================================

Name: ipsl_pcie_dma_tx_arb

Overview:
- Parametrised N-channel TLP arbiter that merges per-source AXI-stream TLP channels (CPLD, MRD, MWR, and future sources) onto one PCIe core AXIS slave port.
- Packet-atomic: once a TLP starts, it completes before any switch. Weighted round-robin between channels.
- Sits between the DMA TX controllers and the hard core's single shared TX AXIS interface. Replaces the fixed three-port wiring.

Parameters:
- CH_NUM, 3, number of input channels (2..8).
- DATA_WIDTH, 128, AXIS tdata width.
- WEIGHT_WIDTH, 4, width of per-channel weight (maximum back-to-back TLPs per grant).
- CNT_WIDTH, 16, width of per-channel TLP counters.

Ports:
- clk  in  1  core user clock (gen1 62.5 MHz, gen2 125 MHz).
- rst_n  in  1  asynchronous active-low reset.
- i_ch_tvld  in  CH_NUM  per-channel tvalid.
- o_ch_trdy  out  CH_NUM  per-channel tready.
- i_ch_tdata  in  CH_NUM*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_ch_tlast  in  CH_NUM  per-channel tlast.
- i_ch_tuser  in  CH_NUM  per-channel tuser.
- i_ch_weight  in  CH_NUM*WEIGHT_WIDTH  per-channel weight; a value of 0 is treated as 1.
- i_axis_trdy  in  1  core tready.
- o_axis_tvld  out  1  merged tvalid.
- o_axis_tdata  out  DATA_WIDTH  merged tdata.
- o_axis_tlast  out  1  merged tlast.
- o_axis_tuser  out  1  merged tuser.
- o_grant  out  CH_NUM  one-hot of the currently granted channel; 0 when idle.
- i_tx_restart  in  1  synchronous clear of the TLP counters.
- o_tlp_cnt  out  CH_NUM*CNT_WIDTH  per-channel count of completed TLPs.

Behaviour:
- Reset values: state IDLE, rr_ptr=0, o_grant=0, o_ch_trdy=0, o_axis_tvld=0, o_axis_tdata=0, o_axis_tlast=0, o_axis_tuser=0, burst_cnt=0, o_tlp_cnt=0.
- FSM has two states, IDLE and BUSY.
- IDLE: if any i_ch_tvld is set, grant the first requesting channel searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., CH_NUM-1, 0, ...). Register the grant, set burst_cnt=0, go to BUSY.
  - Arbitration costs exactly one bubble cycle: a first beat offered in cycle t appears on o_axis_* in cycle t+1 at the earliest.
- BUSY, granted channel g:
  - o_axis_{tvld,tdata,tlast,tuser} are combinational pass-through of channel g.
  - o_ch_trdy[g] = i_axis_trdy. All other trdy bits are 0.
  - Ungranted channels never see trdy.
- End of packet: a handshake (tvld & trdy) with tlast=1.
  - o_tlp_cnt[g] increments; it wraps at 2^CNT_WIDTH.
  - If burst_cnt+1 < eff_weight[g] and i_ch_tvld[g]=1 in that same cycle: stay in BUSY on g, burst_cnt++. No bubble.
  - Otherwise: go to IDLE, rr_ptr = (g+1) mod CH_NUM, o_grant=0.
- Mid-packet, i_ch_tvld[g] may drop. Hold the grant and emit tvld=0 until the packet completes. No timeout.
- i_tx_restart clears all o_tlp_cnt. It does not affect FSM, grant, or rr_ptr.
  - If i_tx_restart coincides with a TLP completion, the counter result is 0 (clear wins).
- rst_n asserted mid-packet: immediate return to reset values. The partial TLP is abandoned; upstream must also be reset.
- Weights are sampled at each end-of-packet decision. Changing them mid-burst takes effect at the next decision.
- A single-beat TLP (tlast on the first beat) is handled identically.

Optional Feature:
- Macro: IPSL_PCIE_TX_ARB_OUT_REG_EN.
- Defined: o_axis_* are driven from a 2-entry skid buffer. Latency from input handshake to output is +1 cycle. Full throughput is sustained under any i_axis_trdy pattern.
  - o_ch_trdy[g] = skid buffer not full; it no longer depends combinationally on i_axis_trdy.
  - End-of-packet decisions use the input-side handshake.
- Undefined: combinational pass-through as described in Behaviour.

Test Plan:
- Single request: ch1 sends a 4-beat TLP, i_axis_trdy=1 → o_grant=3'b010 one cycle after tvld; 4 output beats with tlast on beat 4; o_tlp_cnt[1]=1; FSM returns to IDLE, rr_ptr=2.
- Fair rotation: all three channels continuously offering 2-beat TLPs, weights=1 → grant order 0,1,2,0,1,2; each grant separated by exactly one idle cycle.
- Weighting: weights {ch0=3, ch1=1, ch2=1}, all requesting → ch0 sends 3 back-to-back TLPs with no bubble, then ch1 sends 1, then ch2 sends 1.
- Backpressure: i_axis_trdy toggles 1010..., and ch2 drops tvld mid-TLP for 5 cycles → no data lost or reordered; grant held on ch2 until tlast; o_ch_trdy[0] and o_ch_trdy[1] stay 0 throughout.
- Restart/reset: i_tx_restart pulses in the same cycle as a ch0 tlast handshake → o_tlp_cnt=0 next cycle; rst_n asserted mid-packet → all outputs 0 asynchronously.
- With IPSL_PCIE_TX_ARB_OUT_REG_EN defined, repeat the rotation and backpressure scenarios → identical output beat sequence shifted by one cycle; 100% throughput when i_axis_trdy=1.

Source files
------------

// File: rtl/ipsl_pcie_dma_tx_arb.sv
// N-channel, packet-atomic, weighted round-robin TLP arbiter onto the single PCIe core TX AXIS port.
// Optional IPSL_PCIE_TX_ARB_OUT_REG_EN: drive o_axis_* from a 2-entry skid buffer.

module ipsl_pcie_dma_tx_arb_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);
  // Clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + CNT_WIDTH'(1);
  end
endmodule

module ipsl_pcie_dma_tx_arb #(
  parameter int CH_NUM       = 3,
  parameter int DATA_WIDTH   = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CH_NUM-1:0]              i_ch_tvld,
  output logic [CH_NUM-1:0]              o_ch_trdy,
  input  logic [CH_NUM*DATA_WIDTH-1:0]   i_ch_tdata,
  input  logic [CH_NUM-1:0]              i_ch_tlast,
  input  logic [CH_NUM-1:0]              i_ch_tuser,
  input  logic [CH_NUM*WEIGHT_WIDTH-1:0] i_ch_weight,
  input  logic                           i_axis_trdy,
  output logic                           o_axis_tvld,
  output logic [DATA_WIDTH-1:0]          o_axis_tdata,
  output logic                           o_axis_tlast,
  output logic                           o_axis_tuser,
  output logic [CH_NUM-1:0]              o_grant,
  input  logic                           i_tx_restart,
  output logic [CH_NUM*CNT_WIDTH-1:0]    o_tlp_cnt
);
  localparam int PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int BW    = WEIGHT_WIDTH + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;
  } beat_t;

  state_t                              state, state_nxt;
  logic [PTR_W-1:0]                    rr_ptr, rr_ptr_nxt, gnt, gnt_nxt, pick;
  logic                                pick_vld;
  logic [WEIGHT_WIDTH-1:0]             burst_cnt, burst_cnt_nxt;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0]   ch_tdata;
  logic [CH_NUM-1:0][WEIGHT_WIDTH-1:0] ch_weight;
  logic [CH_NUM-1:0][CNT_WIDTH-1:0]    tlp_cnt;
  logic [CH_NUM-1:0]                   gnt_oh, cnt_inc;
  logic [PTR_W:0]                      cand;
  logic [BW-1:0]                       eff_weight, burst_inc;
  logic                                busy, g_tvld, in_rdy, in_hs, eop;
  beat_t                               in_beat;

  assign ch_tdata  = i_ch_tdata;
  assign ch_weight = i_ch_weight;
  assign busy      = (state == BUSY);

  // First requester at or above rr_ptr, wrapping past CH_NUM-1.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(CH_NUM)) cand = cand - (PTR_W+1)'(CH_NUM);
      if (!pick_vld && i_ch_tvld[cand[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = cand[PTR_W-1:0];
      end
    end
  end

  assign in_beat    = {ch_tdata[gnt], i_ch_tlast[gnt], i_ch_tuser[gnt]};
  assign g_tvld     = busy & i_ch_tvld[gnt];
  assign in_hs      = g_tvld & in_rdy;
  assign eop        = in_hs & in_beat.tlast;
  assign eff_weight = (ch_weight[gnt] == '0) ? BW'(1) : {1'b0, ch_weight[gnt]};
  assign burst_inc  = {1'b0, burst_cnt} + BW'(1);

  always_comb begin
    state_nxt     = state;
    gnt_nxt       = gnt;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt     = BUSY;
          gnt_nxt       = pick;
          burst_cnt_nxt = '0;
        end
      end
      BUSY: begin
        if (eop) begin
          if ((burst_inc < eff_weight) && i_ch_tvld[gnt]) begin
            burst_cnt_nxt = burst_inc[WEIGHT_WIDTH-1:0];
          end else begin
            state_nxt  = IDLE;
            rr_ptr_nxt = (gnt == PTR_W'(CH_NUM-1)) ? '0 : gnt + PTR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      gnt       <= gnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    assign gnt_oh[k]    = busy && (gnt == PTR_W'(k));
    assign o_ch_trdy[k] = gnt_oh[k] & in_rdy;
    assign cnt_inc[k]   = eop & gnt_oh[k];
    ipsl_pcie_dma_tx_arb_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (i_tx_restart),
      .inc   (cnt_inc[k]),
      .cnt   (tlp_cnt[k])
    );
  end

  assign o_grant   = gnt_oh;
  assign o_tlp_cnt = tlp_cnt;

`ifdef IPSL_PCIE_TX_ARB_OUT_REG_EN
  // Two entries let the source stream at full rate while the core's tready
  // is only seen one cycle late through the registered path.
  beat_t      skid [2];
  logic       wr_ptr, rd_ptr, pop;
  logic [1:0] level;

  assign in_rdy = (level != 2'd2);
  assign pop    = o_axis_tvld & i_axis_trdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid[0] <= '0;
      skid[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      level   <= '0;
    end else begin
      if (in_hs) begin
        skid[wr_ptr] <= in_beat;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({in_hs, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: ;
      endcase
    end
  end

  assign o_axis_tvld  = (level != 2'd0);
  assign o_axis_tdata = skid[rd_ptr].tdata;
  assign o_axis_tlast = skid[rd_ptr].tlast;
  assign o_axis_tuser = skid[rd_ptr].tuser;
`else
  assign in_rdy       = i_axis_trdy;
  assign o_axis_tvld  = g_tvld;
  assign o_axis_tdata = busy ? in_beat.tdata : '0;
  assign o_axis_tlast = busy & in_beat.tlast;
  assign o_axis_tuser = busy & in_beat.tuser;
`endif

endmodule

// File: tb/tb_ipsl_pcie_dma_tx_arb.sv
// Randomized scoreboard bench for ipsl_pcie_dma_tx_arb (3 channels, 128-bit data).
module tb_ipsl_pcie_dma_tx_arb;
  localparam int CH = 3, DW = 128, WW = 4, CW = 16;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [CH-1:0]   i_ch_tvld, o_ch_trdy, i_ch_tlast, i_ch_tuser, o_grant;
  logic [CH*DW-1:0] i_ch_tdata;
  logic [CH*WW-1:0] i_ch_weight;
  logic            i_axis_trdy, o_axis_tvld, o_axis_tlast, o_axis_tuser, i_tx_restart;
  logic [DW-1:0]   o_axis_tdata;
  logic [CH*CW-1:0] o_tlp_cnt;

  always #5 clk = ~clk;

  ipsl_pcie_dma_tx_arb #(.CH_NUM(CH), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_ch_tvld(i_ch_tvld), .o_ch_trdy(o_ch_trdy),
    .i_ch_tdata(i_ch_tdata), .i_ch_tlast(i_ch_tlast), .i_ch_tuser(i_ch_tuser),
    .i_ch_weight(i_ch_weight), .i_axis_trdy(i_axis_trdy), .o_axis_tvld(o_axis_tvld),
    .o_axis_tdata(o_axis_tdata), .o_axis_tlast(o_axis_tlast), .o_axis_tuser(o_axis_tuser),
    .o_grant(o_grant), .i_tx_restart(i_tx_restart), .o_tlp_cnt(o_tlp_cnt)
  );

  typedef struct { logic [DW-1:0] d; logic l; logic u; } beat_t;
  typedef struct { int ch; logic [DW-1:0] d; logic l; logic u; } exp_t;

  beat_t src_q [CH][$];
  exp_t  exp_q [$];
  int    tests = 0, fails = 0;
  int    idle_cnt = 0, grants = 0, model_rr = 0;
  int    exp_cnt [CH];
  int    wt [CH];
  bit    mon_en = 0, idle_en = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, o_grant, 0);
    chk({tag, "_ch_trdy"}, o_ch_trdy, 0);
    chk({tag, "_tvld"}, o_axis_tvld, 0);
    chk({tag, "_tdata"}, o_axis_tdata, 0);
    chk({tag, "_tlast"}, o_axis_tlast, 0);
    chk({tag, "_tuser"}, o_axis_tuser, 0);
    chk({tag, "_tlp_cnt"}, o_tlp_cnt, 0);
  endtask

  // Reference: every channel in mask always has a packet waiting, so the grant
  // sequence is pure rotation from model_rr, each grant sending eff_weight packets.
  task automatic build(input logic [CH-1:0] mask, input int rounds, input int lmin, input int lmax);
    int pop, c, w, len;
    beat_t bt;
    exp_t  e;
    pop = 0;
    grants = 0;
    for (int k = 0; k < CH; k++) begin
      if (mask[k]) pop++;
      i_ch_weight[k*WW +: WW] = WW'(wt[k]);
    end
    for (int gi = 0; gi < rounds * pop; gi++) begin
      c = model_rr;
      while (!mask[c]) c = (c + 1) % CH;
      grants++;
      w = (wt[c] == 0) ? 1 : wt[c];
      for (int p = 0; p < w; p++) begin
        len = $urandom_range(lmax, lmin);
        for (int b = 0; b < len; b++) begin
          bt.d = {$urandom, $urandom, $urandom, $urandom};
          bt.l = (b == len - 1);
          bt.u = 1'($urandom_range(1, 0));
          src_q[c].push_back(bt);
          e.ch = c; e.d = bt.d; e.l = bt.l; e.u = bt.u;
          exp_q.push_back(e);
        end
        exp_cnt[c] = (exp_cnt[c] + 1) % 65536;
      end
      model_rr = (c + 1) % CH;
    end
  endtask

  // trdy_mode: 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_phase(input int trdy_mode, input bit drops, input bit restart_at_eop);
    int gap [CH];
    int cyc;
    beat_t dummy;
    cyc = 0;
    for (int k = 0; k < CH; k++) gap[k] = 0;
    idle_cnt = 0;
    idle_en  = 1;
    while (exp_q.size() != 0 && cyc < 5000) begin
      for (int k = 0; k < CH; k++) begin
        if (gap[k] > 0) begin
          gap[k]--;
          i_ch_tvld[k] = 1'b0;
        end else if (src_q[k].size() > 0) begin
          i_ch_tvld[k]            = 1'b1;
          i_ch_tdata[k*DW +: DW]  = src_q[k][0].d;
          i_ch_tlast[k]           = src_q[k][0].l;
          i_ch_tuser[k]           = src_q[k][0].u;
        end else begin
          i_ch_tvld[k]  = 1'b0;
          i_ch_tlast[k] = 1'b0;
        end
      end
      case (trdy_mode)
        0:       i_axis_trdy = 1'b1;
        1:       i_axis_trdy = (cyc % 2 == 0);
        default: i_axis_trdy = 1'($urandom_range(1, 0));
      endcase
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        if (i_ch_tvld[k] && o_ch_trdy[k]) begin
          if (restart_at_eop && k == 0 && i_ch_tlast[0]) i_tx_restart = 1'b1;
          dummy = src_q[k].pop_front();
          if (drops && !i_ch_tlast[k] && $urandom_range(3, 0) == 0)
            gap[k] = ($urandom_range(1, 0) == 1) ? 5 : $urandom_range(3, 1);
        end
      end
      @(posedge clk); #1;
      i_tx_restart = 1'b0;
      cyc++;
    end
    idle_en = 0;
    if (cyc >= 5000) begin
      chk("phase_timeout", exp_q.size(), 0);
      exp_q.delete();
      for (int k = 0; k < CH; k++) src_q[k].delete();
    end
    i_ch_tvld  = '0;
    i_ch_tlast = '0;
    i_ch_tuser = '0;
  endtask

  task automatic post_check(input string tag);
`ifndef IPSL_PCIE_TX_ARB_OUT_REG_EN
    chk({tag, "_bubbles"}, idle_cnt, grants);
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++)
      chk($sformatf("%s_cnt%0d", tag, k), o_tlp_cnt[k*CW +: CW], exp_cnt[k]);
  endtask

  // Monitor: pops the scoreboard on every accepted output beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        chk("trdy_ungranted", o_ch_trdy & ~o_grant, 0);
        if (idle_en && o_grant == '0) idle_cnt++;
        if (o_axis_tvld && i_axis_trdy) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got tdata %0h with empty scoreboard", o_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", o_axis_tdata, e.d);
            chk("tlast", o_axis_tlast, e.l);
            chk("tuser", o_axis_tuser, e.u);
`ifndef IPSL_PCIE_TX_ARB_OUT_REG_EN
            chk($sformatf("grant_ch%0d", e.ch), o_grant, CH'(1) << e.ch);
`endif
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    i_ch_tvld = '0; i_ch_tlast = '0; i_ch_tuser = '0; i_ch_tdata = '0;
    i_ch_weight = '0; i_axis_trdy = 1'b0; i_tx_restart = 1'b0;
    for (int k = 0; k < CH; k++) begin exp_cnt[k] = 0; wt[k] = 1; end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("after_reset");
    mon_en = 1;

    // single 4-beat request on ch1
    wt = '{1, 1, 1};
    build(3'b010, 1, 4, 4);
    run_phase(0, 0, 0);
    post_check("single");

    // fair rotation, 2-beat TLPs, starts at ch2 after the single request
    build(3'b111, 2, 2, 2);
    run_phase(0, 0, 0);
    post_check("rotate");

    // weighting 3/1/1
    wt = '{3, 1, 1};
    build(3'b111, 2, 1, 4);
    run_phase(0, 0, 0);
    post_check("weight");

    // toggling tready plus mid-packet tvld drops
    wt = '{2, 1, 3};
    build(3'b111, 3, 2, 6);
    run_phase(1, 1, 0);
    post_check("bkpr");

    // random weights including 0, random tready
    for (int k = 0; k < CH; k++) wt[k] = $urandom_range(4, 0);
    build(3'b111, 3, 1, 5);
    run_phase(2, 1, 0);
    post_check("random");

    // asynchronous reset in the middle of a ch1 packet
    mon_en = 0;
    i_axis_trdy = 1'b1;
    i_ch_tdata[1*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
    i_ch_tlast = '0;
    i_ch_tvld  = 3'b010;
    for (int n = 0; n < 10 && o_grant != 3'b010; n++) @(negedge clk);
    chk("rst_pre_grant", o_grant, 3'b010);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_pkt_reset");
    i_ch_tvld = '0;
    i_axis_trdy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_rr = 0;
    for (int k = 0; k < CH; k++) exp_cnt[k] = 0;
    @(posedge clk);
    #1 mon_en = 1;

    // restart coinciding with a ch0 end-of-packet: clear wins
    wt = '{1, 1, 1};
    build(3'b001, 1, 1, 3);
    for (int k = 0; k < CH; k++) exp_cnt[k] = 0;
    run_phase(0, 0, 1);
    post_check("restart");

    // recovery after reset/restart
    build(3'b111, 2, 1, 3);
    run_phase(2, 0, 0);
    post_check("recover");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
